proto245_cmd_engine: RTL and testbench

- Register-access command engine on the user (FIFO) side of proto245a.
- Pops host bytes from the proto245a RX FIFO and parses them into read/write frames.
- Executes each frame on a simple request/acknowledge register bus, then pushes a response frame into the proto245a TX FIFO.
- Lets the host reach on-chip control/status registers over the FT245 link.

---
 rtl/proto245_cmd_pkg.sv | 21 ++
 rtl/proto245_cmd_txser.sv | 40 ++++
 rtl/proto245_cmd_engine.sv | 187 ++++++++++++++++++
 tb/tb_proto245_cmd_engine.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/proto245_cmd_pkg.sv
// rtl/proto245_cmd_pkg.sv - opcodes, response codes and FSM states for the proto245a command engine
package proto245_cmd_pkg;

  localparam logic [7:0] OP_WR   = 8'hA5;
  localparam logic [7:0] OP_RD   = 8'h5A;
  localparam logic [7:0] RSP_OK  = 8'hAC;
  localparam logic [7:0] RSP_ERR = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_BUS,
    S_RESP
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/proto245_cmd_txser.sv
// rtl/proto245_cmd_txser.sv - response serializer draining a loaded byte buffer into the TX FIFO
// Byte 0 of i_bytes goes out first; one push per cycle the FIFO is not full.
module proto245_cmd_txser #(
  parameter int NBYTES = 5,
  parameter int LEN_W  = $clog2(NBYTES + 1)
) (
  input  logic                  fifo_clk,
  input  logic                  fifo_rstn,
  input  logic                  i_load,
  input  logic [NBYTES*8-1:0]   i_bytes,
  input  logic [LEN_W-1:0]      i_len,
  input  logic                  txfifo_full,
  output logic [7:0]            txfifo_data,
  output logic                  txfifo_wr,
  output logic                  o_done
);

  logic [NBYTES*8-1:0] r_buf;
  logic [LEN_W-1:0]    r_cnt;
  logic                w_push;

  assign w_push      = (r_cnt != '0) && !txfifo_full;
  assign txfifo_wr   = w_push;
  assign txfifo_data = r_buf[7:0];
  assign o_done      = w_push && (r_cnt == LEN_W'(1));

  always_ff @(posedge fifo_clk or negedge fifo_rstn) begin
    if (!fifo_rstn) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_buf <= i_bytes;
      r_cnt <= i_len;
    end else if (w_push) begin
      r_buf <= r_buf >> 8;
      r_cnt <= r_cnt - LEN_W'(1);
    end
  end

endmodule

// File: rtl/proto245_cmd_engine.sv
// rtl/proto245_cmd_engine.sv - host register-access engine: RX frame parser, bus master, TX responder
// Frames: A5 addr d0..dN (write) / 5A addr (read); replies AC [data] or EE.
module proto245_cmd_engine
  import proto245_cmd_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int REG_W       = 32,
  parameter int BUS_TIMEOUT = 64,
  parameter int RX_TIMEOUT  = 1024
) (
  input  logic              fifo_clk,
  input  logic              fifo_rstn,
  output logic              rxfifo_rd,
  input  logic [DATA_W-1:0] rxfifo_data,
  input  logic              rxfifo_valid,
  input  logic              rxfifo_empty,
  output logic [DATA_W-1:0] txfifo_data,
  output logic              txfifo_wr,
  input  logic              txfifo_full,
  output logic              bus_wr,
  output logic              bus_rd,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [REG_W-1:0]  bus_wdata,
  input  logic [REG_W-1:0]  bus_rdata,
  input  logic              bus_ack,
  output logic [7:0]        err_cnt
);

  localparam int NB    = REG_W / 8;
  localparam int TXN   = NB + 1;
  localparam int LEN_W = $clog2(TXN + 1);
  localparam int BC_W  = $clog2(NB + 1);
  localparam int RXT_W = $clog2(RX_TIMEOUT + 1);
  localparam int BT_W  = $clog2(BUS_TIMEOUT + 1);
  localparam logic [BC_W-1:0] LAST_B = BC_W'(NB - 1);

  generate
    if (DATA_W != 8) begin : g_bad_data_w
      $fatal(1, "proto245_cmd_engine: DATA_W must be 8");
    end
  endgenerate

  state_t               r_state;
  logic                 r_pop_pend;
  logic                 r_is_wr;
  logic [BC_W-1:0]      r_bcnt;
  logic [RXT_W-1:0]     r_idle;
  logic [BT_W-1:0]      r_tmo;
  logic                 r_bus_wr;
  logic                 r_bus_rd;
  logic [ADDR_W-1:0]    r_addr;
  logic [REG_W-1:0]     r_wdata;
  logic [7:0]           r_err;
  logic                 r_tx_load;
  logic [TXN*8-1:0]     r_tx_bytes;
  logic [LEN_W-1:0]     r_tx_len;
  logic                 w_collect;
  logic                 w_take;
  logic                 w_tx_done;
  logic [7:0]           w_tx_byte;

  assign w_collect = (r_state == S_IDLE) || (r_state == S_ADDR) || (r_state == S_WDATA);
  assign rxfifo_rd = w_collect && !rxfifo_empty && !r_pop_pend;
  // Only the first valid after a pop belongs to us; stray valids are ignored.
  assign w_take    = r_pop_pend && rxfifo_valid;

  assign bus_wr      = r_bus_wr;
  assign bus_rd      = r_bus_rd;
  assign bus_addr    = r_addr;
  assign bus_wdata   = r_wdata;
  assign err_cnt     = r_err;
  assign txfifo_data = w_tx_byte;

  always_ff @(posedge fifo_clk or negedge fifo_rstn) begin
    if (!fifo_rstn) r_pop_pend <= 1'b0;
    else            r_pop_pend <= rxfifo_rd | (r_pop_pend & ~rxfifo_valid);
  end

  always_ff @(posedge fifo_clk or negedge fifo_rstn) begin
    if (!fifo_rstn) begin
      r_state    <= S_IDLE;
      r_is_wr    <= 1'b0;
      r_bcnt     <= '0;
      r_idle     <= '0;
      r_tmo      <= '0;
      r_bus_wr   <= 1'b0;
      r_bus_rd   <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_err      <= '0;
      r_tx_load  <= 1'b0;
      r_tx_bytes <= '0;
      r_tx_len   <= '0;
    end else begin
      r_tx_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            if (rxfifo_data == OP_WR || rxfifo_data == OP_RD) begin
              r_is_wr <= (rxfifo_data == OP_WR);
              r_idle  <= '0;
              r_state <= S_ADDR;
            end else begin
              r_tx_bytes <= (TXN*8)'(RSP_ERR);
              r_tx_len   <= LEN_W'(1);
              r_tx_load  <= 1'b1;
              r_err      <= sat_inc8(r_err);
              r_state    <= S_RESP;
            end
          end
        end
        S_ADDR, S_WDATA: begin
          if (w_take) begin
            r_idle <= '0;
            if (r_state == S_ADDR) begin
              r_addr <= ADDR_W'(rxfifo_data);
              r_bcnt <= '0;
              if (r_is_wr) begin
                r_state <= S_WDATA;
              end else begin
                r_bus_rd <= 1'b1;
                r_tmo    <= '0;
                r_state  <= S_BUS;
              end
            end else begin
              r_wdata[int'(r_bcnt)*8 +: 8] <= rxfifo_data;
              r_bcnt <= r_bcnt + BC_W'(1);
              if (r_bcnt == LAST_B) begin
                r_bus_wr <= 1'b1;
                r_tmo    <= '0;
                r_state  <= S_BUS;
              end
            end
          end else if (r_idle == RXT_W'(RX_TIMEOUT - 1)) begin
            r_idle  <= '0;
            r_err   <= sat_inc8(r_err);
            r_state <= S_IDLE;
          end else begin
            r_idle <= r_idle + RXT_W'(1);
          end
        end
        S_BUS: begin
          // Ack is checked first so a last-cycle ack still counts as success.
          if (bus_ack) begin
            r_bus_wr   <= 1'b0;
            r_bus_rd   <= 1'b0;
            r_tx_bytes <= {bus_rdata, RSP_OK};
            r_tx_len   <= r_bus_rd ? LEN_W'(TXN) : LEN_W'(1);
            r_tx_load  <= 1'b1;
            r_state    <= S_RESP;
          end else if (r_tmo == BT_W'(BUS_TIMEOUT - 1)) begin
            r_bus_wr   <= 1'b0;
            r_bus_rd   <= 1'b0;
            r_tx_bytes <= (TXN*8)'(RSP_ERR);
            r_tx_len   <= LEN_W'(1);
            r_tx_load  <= 1'b1;
            r_err      <= sat_inc8(r_err);
            r_state    <= S_RESP;
          end else begin
            r_tmo <= r_tmo + BT_W'(1);
          end
        end
        S_RESP: begin
          if (w_tx_done) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  proto245_cmd_txser #(
    .NBYTES (TXN),
    .LEN_W  (LEN_W)
  ) u_txser (
    .fifo_clk    (fifo_clk),
    .fifo_rstn   (fifo_rstn),
    .i_load      (r_tx_load),
    .i_bytes     (r_tx_bytes),
    .i_len       (r_tx_len),
    .txfifo_full (txfifo_full),
    .txfifo_data (w_tx_byte),
    .txfifo_wr   (txfifo_wr),
    .o_done      (w_tx_done)
  );

endmodule

// File: tb/tb_proto245_cmd_engine.sv
// tb/tb_proto245_cmd_engine.sv - directed self-checking bench for proto245_cmd_engine
module tb_proto245_cmd_engine;

  localparam int BUS_TO = 16;
  localparam int RX_TO  = 40;

  logic        fifo_clk;
  logic        fifo_rstn;
  logic        rxfifo_rd;
  logic [7:0]  rxfifo_data;
  logic        rxfifo_valid;
  logic        rxfifo_empty;
  logic [7:0]  txfifo_data;
  logic        txfifo_wr;
  logic        txfifo_full;
  logic        bus_wr;
  logic        bus_rd;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [7:0]  err_cnt;

  proto245_cmd_engine #(
    .DATA_W      (8),
    .ADDR_W      (8),
    .REG_W       (32),
    .BUS_TIMEOUT (BUS_TO),
    .RX_TIMEOUT  (RX_TO)
  ) dut (
    .fifo_clk     (fifo_clk),
    .fifo_rstn    (fifo_rstn),
    .rxfifo_rd    (rxfifo_rd),
    .rxfifo_data  (rxfifo_data),
    .rxfifo_valid (rxfifo_valid),
    .rxfifo_empty (rxfifo_empty),
    .txfifo_data  (txfifo_data),
    .txfifo_wr    (txfifo_wr),
    .txfifo_full  (txfifo_full),
    .bus_wr       (bus_wr),
    .bus_rd       (bus_rd),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_rdata    (bus_rdata),
    .bus_ack      (bus_ack),
    .err_cnt      (err_cnt)
  );

  initial begin
    fifo_clk = 1'b0;
    forever #5 fifo_clk = ~fifo_clk;
  end

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_q[$];
  int          rd_log[$];
  int          push_log[$];
  int          cyc = 0;
  bit          deliver = 0;
  bit          ack_en = 1;
  bit          full_mode = 0;
  int          wr_acc = 0;
  int          rd_high = 0;
  int          full_viol = 0;
  int          rd_while_empty = 0;
  logic [7:0]  last_addr = 8'h00;
  logic [31:0] last_wdata = 32'h0;
  int          n_total = 0;
  int          n_bad = 0;

  // Environment: RX FIFO with 1-cycle read latency, TX FIFO sink, 1-cycle-ack register bus.
  initial begin
    rxfifo_valid = 1'b0;
    rxfifo_data  = 8'h00;
    rxfifo_empty = 1'b1;
    txfifo_full  = 1'b0;
    bus_ack      = 1'b0;
    forever begin
      @(negedge fifo_clk);
      cyc++;
      rxfifo_valid = 1'b0;
      if (deliver) begin
        rxfifo_valid = 1'b1;
        rxfifo_data  = rx_q.pop_front();
        deliver      = 0;
      end
      rxfifo_empty = (rx_q.size() == 0);
      txfifo_full  = full_mode && (cyc % 3 != 0);
      bus_ack      = 1'b0;
      if (bus_wr && ack_en) begin
        bus_ack    = 1'b1;
        wr_acc++;
        last_addr  = bus_addr;
        last_wdata = bus_wdata;
      end
      if (bus_rd && ack_en) begin
        bus_ack   = 1'b1;
        last_addr = bus_addr;
      end
      if (bus_rd) rd_high++;
      #1;
      if (rxfifo_rd) begin
        if (rxfifo_empty) rd_while_empty++;
        deliver = 1;
        rd_log.push_back(cyc);
      end
      if (txfifo_wr) begin
        if (txfifo_full) full_viol++;
        tx_q.push_back(txfifo_data);
        push_log.push_back(cyc);
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_q.push_back(b);
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    int k = 0;
    while (tx_q.size() < n && k < budget) begin
      @(posedge fifo_clk);
      k++;
    end
    check_eq({tag, "_count"}, 64'(tx_q.size()), 64'(n));
  endtask

  task automatic expect_tx(input string tag, input logic [7:0] b);
    logic [7:0] v = 8'hxx;
    if (tx_q.size() > 0) v = tx_q.pop_front();
    check_eq(tag, 64'(v), 64'(b));
  endtask

  task automatic expect_read_rsp(input string tag, input logic [31:0] d);
    expect_tx({tag, "_ok"}, 8'hAC);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t = d >> (8 * i);
      expect_tx($sformatf("%s_b%0d", tag, i), t[7:0]);
    end
  endtask

  initial begin
    fifo_rstn = 1'b0;
    bus_rdata = 32'h0;
    repeat (3) @(posedge fifo_clk);
    @(negedge fifo_clk);
    #2;
    check_eq("rst_rxfifo_rd", 64'(rxfifo_rd), 64'd0);
    check_eq("rst_txfifo_wr", 64'(txfifo_wr), 64'd0);
    check_eq("rst_bus_wr", 64'(bus_wr), 64'd0);
    check_eq("rst_bus_rd", 64'(bus_rd), 64'd0);
    check_eq("rst_err_cnt", 64'(err_cnt), 64'd0);
    check_eq("rst_bus_wdata", 64'(bus_wdata), 64'd0);
    fifo_rstn = 1'b1;

    // Write frame.
    send(8'hA5); send(8'h10); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    wait_tx("wr", 1, 200);
    expect_tx("wr_rsp", 8'hAC);
    repeat (10) @(posedge fifo_clk);
    check_eq("wr_once", 64'(wr_acc), 64'd1);
    check_eq("wr_addr", 64'(last_addr), 64'h10);
    check_eq("wr_data", 64'(last_wdata), 64'h12345678);

    // Read frame.
    bus_rdata = 32'hDEADBEEF;
    send(8'h5A); send(8'h20);
    wait_tx("rd", 5, 200);
    expect_read_rsp("rd", 32'hDEADBEEF);
    check_eq("rd_addr", 64'(last_addr), 64'h20);

    // Bad opcode then a valid read.
    send(8'h33); send(8'h5A); send(8'h20);
    wait_tx("badop", 6, 300);
    expect_tx("badop_err", 8'hEE);
    expect_read_rsp("badop_rd", 32'hDEADBEEF);
    check_eq("badop_err_cnt", 64'(err_cnt), 64'd1);

    // Bus timeout.
    repeat (5) @(posedge fifo_clk);
    ack_en  = 0;
    rd_high = 0;
    send(8'h5A); send(8'h40);
    wait_tx("bto", 1, 200);
    expect_tx("bto_rsp", 8'hEE);
    check_eq("bto_rd_cycles", 64'(rd_high), 64'(BUS_TO));
    check_eq("bto_err_cnt", 64'(err_cnt), 64'd2);
    ack_en = 1;
    repeat (5) @(posedge fifo_clk);

    // Reset, then RX idle timeout on a partial write.
    @(negedge fifo_clk);
    fifo_rstn = 1'b0;
    repeat (2) @(negedge fifo_clk);
    check_eq("rst2_err_cnt", 64'(err_cnt), 64'd0);
    fifo_rstn = 1'b1;
    wr_acc = 0;
    send(8'hA5); send(8'h10);
    repeat (RX_TO + 30) @(posedge fifo_clk);
    check_eq("rxto_no_tx", 64'(tx_q.size()), 64'd0);
    check_eq("rxto_err_cnt", 64'(err_cnt), 64'd1);
    check_eq("rxto_no_bus", 64'(wr_acc), 64'd0);
    send(8'h5A); send(8'h00);
    wait_tx("rxto_rd", 5, 200);
    expect_read_rsp("rxto_rd", 32'hDEADBEEF);
    check_eq("rxto_rd_addr", 64'(last_addr), 64'h00);

    // TX back-pressure, with a second frame already queued.
    repeat (5) @(posedge fifo_clk);
    bus_rdata = 32'hCAFE1234;
    rd_log.delete();
    push_log.delete();
    full_viol = 0;
    full_mode = 1;
    send(8'h5A); send(8'h21); send(8'h5A); send(8'h22);
    wait_tx("bp", 10, 400);
    expect_read_rsp("bp_first", 32'hCAFE1234);
    expect_read_rsp("bp_second", 32'hCAFE1234);
    check_eq("bp_no_push_full", 64'(full_viol), 64'd0);
    check_eq("bp_pop_after_push",
             64'((rd_log.size() >= 3 && push_log.size() >= 5) ? (rd_log[2] > push_log[4]) : 0),
             64'd1);
    full_mode = 0;
    check_eq("no_rd_while_empty", 64'(rd_while_empty), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
